date_set_ctrl: RTL and testbench
================================

// Module: date_set_ctrl
// PURPOSE
//  Sequences user editing of the calendar date and loads it into date_module.
//  Snapshots the running date, steps through day -> month -> year fields on
//  button presses, clamps the day to a valid value, then issues a one-cycle
//  date_ow pulse with the edited word on date_set (wired to date_module.date_in).
//  Sits between the debounced button block and date_module; drives display blink.
// PARAMETERS
//  YEARRES      12        year field width; must match date_module
//  TIMEOUT_CYC  50000000  idle cycles in an edit state before abort (no write)
// PORTS
//  clk        in   1            system clock
//  rst        in   1            synchronous, active-high reset
//  btn_mode   in   1            debounced level: enter edit / next field / commit
//  btn_inc    in   1            debounced level: increment selected field
//  btn_dec    in   1            debounced level: decrement selected field
//  date_cur   in   YEARRES+9    running date {ddddd,mmmm,year} from date_module
//  date_set   out  YEARRES+9    edited date to date_module.date_in
//  date_ow    out  1            one-cycle load pulse to date_module.date_ow
//  editing    out  1            high in EDIT_DAY/EDIT_MONTH/EDIT_YEAR
//  field_sel  out  2            0 none, 1 day, 2 month, 3 year (display blink)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. rst wins over all inputs.
//    Reset: state IDLE, date_ow 0, editing 0, field_sel 0,
//    date_set {5'd1,4'd1,YEARRES'd0}, edge regs 0, timeout counter 0.
//  - Buttons rising-edge detected internally (1 registered delay); a held
//    button yields exactly one event. Events are used the cycle after the edge.
//  - FSM: IDLE -mode-> EDIT_DAY (shadow <= date_cur same cycle)
//    EDIT_DAY -mode-> EDIT_MONTH -mode-> EDIT_YEAR -mode-> COMMIT -> IDLE.
//    COMMIT lasts exactly 1 cycle; date_ow=1 only in COMMIT.
//  - date_set is registered; it updates in COMMIT's preceding cycle so it is
//    stable when date_ow rises and holds its value until the next COMMIT.
//  - inc/dec in IDLE ignored. Same-cycle inc+dec edge: both ignored.
//    mode edge with inc/dec in same cycle: mode wins, inc/dec discarded.
//  - Day: range 1..maxd(month,year); inc at maxd -> 1; dec at 1 -> maxd.
//    maxd: Feb 29 if year[1:0]==0 else 28; Apr/Jun/Sep/Nov 30; others 31.
//  - Month: 1..12 wrap both ways. Year: modulo 2^YEARRES wrap both ways.
//  - Out-of-range snapshot (day 0 or >31, month 0 or >12) is forced to 1 on
//    entry to EDIT_DAY.
//  - Day clamp: on the EDIT_YEAR -> COMMIT transition, day > maxd(final month,
//    final year) is set to maxd (e.g. 31/04 -> 30/04, 29/02 common -> 28/02).
//  - Timeout: counter clears on any button event; reaching TIMEOUT_CYC-1 in an
//    edit state -> IDLE, no date_ow, date_set unchanged. Counter 0 in IDLE.
//  - date_cur is sampled only at IDLE->EDIT_DAY; later changes (rollover during
//    edit) are ignored and overwritten by the commit.
// STRUCTURE
//  - Shared package date_pkg: field_sel encodings (FLD_NONE/DAY/MONTH/YEAR),
//    month constants, and date word field offsets for YEARRES.
//  - Sub-module days_in_month (combinational): month[3:0], leap -> maxd[4:0];
//    shared with later calendar blocks. Edge detect and FSM stay inline.
// TESTING
//  1 rst held 3 cycles with buttons high -> date_ow 0, field_sel 0,
//    date_set {1,1,0}; no event after release until a new edge.
//  2 date_cur=15/06/2021; mode, inc x3, mode, mode, mode -> single date_ow
//    pulse, date_set=18/06/2021, editing 0 afterwards.
//  3 day 31 month 01, inc -> day 1; dec at 1 in Feb year 2024 -> 29;
//    month dec at 1 -> 12; year inc at 4095 (YEARRES=12) -> 0.
//  4 Clamp: snapshot 31/01/2023, month inc -> 2, commit -> date_set 28/02/2023;
//    same with year 2024 -> 29/02/2024.
//  5 Held inc for 100 cycles -> exactly one increment; inc+dec same cycle ->
//    no change; mode+inc same cycle -> field advances, value unchanged.
//  6 TIMEOUT_CYC=16: enter edit, no presses -> IDLE after 16 cycles, no
//    date_ow; rst asserted in EDIT_MONTH -> IDLE next cycle, no date_ow.

Source files
------------

// File: rtl/date_pkg.sv
// Shared calendar definitions: field select encodings, month numbers and
// the layout of the {day, month, year} date word.
package date_pkg;

    typedef enum logic [1:0] {
        FLD_NONE  = 2'd0,
        FLD_DAY   = 2'd1,
        FLD_MONTH = 2'd2,
        FLD_YEAR  = 2'd3
    } field_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_DAY,
        ST_EDIT_MONTH,
        ST_EDIT_YEAR,
        ST_COMMIT
    } set_state_t;

    localparam int DAY_W = 5;
    localparam int MON_W = 4;

    localparam logic [3:0] MON_JAN = 4'd1;
    localparam logic [3:0] MON_FEB = 4'd2;
    localparam logic [3:0] MON_APR = 4'd4;
    localparam logic [3:0] MON_JUN = 4'd6;
    localparam logic [3:0] MON_SEP = 4'd9;
    localparam logic [3:0] MON_NOV = 4'd11;
    localparam logic [3:0] MON_DEC = 4'd12;

    // Date word is {day, month, year} with the year in the low bits.
    function automatic int date_w(input int yearres);
        return yearres + MON_W + DAY_W;
    endfunction

    function automatic int mon_lsb(input int yearres);
        return yearres;
    endfunction

    function automatic int day_lsb(input int yearres);
        return yearres + MON_W;
    endfunction

endpackage

// File: rtl/days_in_month.sv
// Number of days in a month; leap selects the 29-day February.
module days_in_month
    import date_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap,
    output logic [4:0] maxd
);

    always_comb begin
        maxd = 5'd31;
        case (month)
            MON_FEB:                            maxd = leap ? 5'd29 : 5'd28;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: maxd = 5'd30;
            default:                            maxd = 5'd31;
        endcase
    end

endmodule

// File: rtl/date_set_ctrl.sv
// User date editing: snapshot the running date, step day/month/year with
// button events, then load the edited word into date_module with date_ow.
module date_set_ctrl
    import date_pkg::*;
#(
    parameter int YEARRES     = 12,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_mode,
    input  logic                          btn_inc,
    input  logic                          btn_dec,
    input  logic [date_w(YEARRES)-1:0]    date_cur,
    output logic [date_w(YEARRES)-1:0]    date_set,
    output logic                          date_ow,
    output logic                          editing,
    output logic [1:0]                    field_sel
);

    localparam int DW      = date_w(YEARRES);
    localparam int MON_LSB = mon_lsb(YEARRES);
    localparam int DAY_LSB = day_lsb(YEARRES);
    localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic              mode_q, inc_q, dec_q;
    logic              ev_mode, ev_inc, ev_dec;
    set_state_t        state;
    logic [CNT_W-1:0]  cnt;

    logic [DAY_W-1:0]   day_sh;
    logic [MON_W-1:0]   mon_sh;
    logic [YEARRES-1:0] year_sh;

    logic [DAY_W-1:0]   cur_day;
    logic [MON_W-1:0]   cur_mon;
    logic [4:0]         maxd;
    logic               any_ev, inc_ok, dec_ok;
    logic [DAY_W-1:0]   day_inc, day_dec, day_clamp;
    logic [MON_W-1:0]   mon_inc, mon_dec;

    assign cur_day = date_cur[DAY_LSB +: DAY_W];
    assign cur_mon = date_cur[MON_LSB +: MON_W];

    days_in_month u_dim (
        .month (mon_sh),
        .leap  (year_sh[1:0] == 2'b00),
        .maxd  (maxd)
    );

    // Conflicting events cancel; mode always takes precedence over inc/dec.
    always_comb begin
        any_ev    = ev_mode | ev_inc | ev_dec;
        inc_ok    = ev_inc & ~ev_dec & ~ev_mode;
        dec_ok    = ev_dec & ~ev_inc & ~ev_mode;
        day_inc   = (day_sh >= maxd) ? 5'd1 : day_sh + 5'd1;
        day_dec   = (day_sh <= 5'd1 || day_sh > maxd) ? maxd : day_sh - 5'd1;
        day_clamp = (day_sh > maxd) ? maxd : day_sh;
        mon_inc   = (mon_sh >= MON_DEC) ? MON_JAN : mon_sh + 4'd1;
        mon_dec   = (mon_sh <= MON_JAN) ? MON_DEC : mon_sh - 4'd1;
    end

    always_ff @(posedge clk) begin
        // Delay regs keep tracking through reset so a button held across
        // reset release does not produce a spurious event.
        mode_q <= btn_mode;
        inc_q  <= btn_inc;
        dec_q  <= btn_dec;

        if (rst) begin
            ev_mode   <= 1'b0;
            ev_inc    <= 1'b0;
            ev_dec    <= 1'b0;
            state     <= ST_IDLE;
            date_ow   <= 1'b0;
            editing   <= 1'b0;
            field_sel <= FLD_NONE;
            date_set  <= {5'd1, 4'd1, {YEARRES{1'b0}}};
            cnt       <= '0;
        end else begin
            ev_mode <= btn_mode & ~mode_q;
            ev_inc  <= btn_inc & ~inc_q;
            ev_dec  <= btn_dec & ~dec_q;
            date_ow <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (ev_mode) begin
                        state     <= ST_EDIT_DAY;
                        editing   <= 1'b1;
                        field_sel <= FLD_DAY;
                        day_sh    <= (cur_day == 5'd0) ? 5'd1 : cur_day;
                        mon_sh    <= (cur_mon == 4'd0 || cur_mon > MON_DEC) ? MON_JAN : cur_mon;
                        year_sh   <= date_cur[YEARRES-1:0];
                    end
                end

                ST_EDIT_DAY, ST_EDIT_MONTH, ST_EDIT_YEAR: begin
                    cnt <= any_ev ? '0 : cnt + CNT_W'(1);
                    if (ev_mode) begin
                        case (state)
                            ST_EDIT_DAY: begin
                                state     <= ST_EDIT_MONTH;
                                field_sel <= FLD_MONTH;
                            end
                            ST_EDIT_MONTH: begin
                                state     <= ST_EDIT_YEAR;
                                field_sel <= FLD_YEAR;
                            end
                            default: begin
                                state     <= ST_COMMIT;
                                editing   <= 1'b0;
                                field_sel <= FLD_NONE;
                                date_ow   <= 1'b1;
                                day_sh    <= day_clamp;
                                date_set  <= {day_clamp, mon_sh, year_sh};
                            end
                        endcase
                    end else if (!any_ev && cnt == CNT_LAST) begin
                        state     <= ST_IDLE;
                        editing   <= 1'b0;
                        field_sel <= FLD_NONE;
                        cnt       <= '0;
                    end else if (inc_ok || dec_ok) begin
                        case (state)
                            ST_EDIT_DAY:   day_sh  <= inc_ok ? day_inc : day_dec;
                            ST_EDIT_MONTH: mon_sh  <= inc_ok ? mon_inc : mon_dec;
                            default:       year_sh <= inc_ok ? year_sh + 1'b1 : year_sh - 1'b1;
                        endcase
                    end
                end

                ST_COMMIT: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end

                default: begin
                    state     <= ST_IDLE;
                    editing   <= 1'b0;
                    field_sel <= FLD_NONE;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_date_set_ctrl.sv
// Scoreboard bench for date_set_ctrl: expected commit words are queued by
// the stimulus and popped by a monitor on every date_ow pulse.
module tb_date_set_ctrl;

    localparam int YR = 12;
    localparam int DW = YR + 9;
    localparam logic [DW-1:0] RST_SET = {5'd1, 4'd1, 12'd0};

    logic          clk = 1'b0;
    logic          rst, btn_mode, btn_inc, btn_dec, to_mode;
    logic [DW-1:0] date_cur, date_set, to_set;
    logic          date_ow, editing, to_ow, to_editing;
    logic [1:0]    field_sel, to_field;
    logic          mon_en = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    date_set_ctrl #(.YEARRES(YR), .TIMEOUT_CYC(1000)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .date_cur(date_cur), .date_set(date_set),
        .date_ow(date_ow), .editing(editing), .field_sel(field_sel)
    );

    date_set_ctrl #(.YEARRES(YR), .TIMEOUT_CYC(16)) dut_to (
        .clk(clk), .rst(rst), .btn_mode(to_mode), .btn_inc(1'b0),
        .btn_dec(1'b0), .date_cur(date_cur), .date_set(to_set),
        .date_ow(to_ow), .editing(to_editing), .field_sel(to_field)
    );

    function automatic logic [DW-1:0] mk(input int d, input int m, input int y);
        return {5'(d), 4'(m), 12'(y)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        if (mon_en) begin
            if (date_ow === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_date_ow: date_set=%0h, no commit expected", date_set);
                end else begin
                    e = exp_q.pop_front();
                    if (date_set !== e) begin
                        errors++;
                        $display("FAIL commit_word: got %0h expected %0h", date_set, e);
                    end
                end
            end
            if (to_ow !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL timeout_date_ow: got %b expected 0", to_ow);
            end
        end
    end

    task automatic press(input logic m, input logic i, input logic d, input int hold = 1);
        @(negedge clk);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        @(negedge clk);
    endtask

    // ops: m=mode i=inc d=dec b=inc+dec x=mode+inc h=inc held 100 cycles
    task automatic session(input string name, input logic [DW-1:0] cur,
                           input string ops, input logic [DW-1:0] exp);
        date_cur = cur;
        exp_q.push_back(exp);
        for (int k = 0; k < ops.len(); k++) begin
            case (ops[k])
                "m": press(1, 0, 0);
                "i": press(0, 1, 0);
                "d": press(0, 0, 1);
                "b": press(0, 1, 1);
                "x": press(1, 1, 0);
                "h": press(0, 1, 0, 100);
                default: ;
            endcase
        end
        repeat (3) @(negedge clk);
        check({name, "_committed"}, exp_q.size(), 0);
        check({name, "_editing_off"}, editing, 0);
        check({name, "_field_none"}, field_sel, 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; btn_mode = 1'b1; btn_inc = 1'b1; btn_dec = 1'b1;
        to_mode = 1'b0; date_cur = '0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check("rst_date_ow", date_ow, 0);
        check("rst_field_sel", field_sel, 0);
        check("rst_editing", editing, 0);
        check("rst_date_set", date_set, RST_SET);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("held_after_rst_no_edit", editing, 0);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (2) @(negedge clk);

        // Basic edit with field_sel tracking
        date_cur = mk(15, 6, 2021);
        exp_q.push_back(mk(18, 6, 2021));
        press(1, 0, 0);
        check("enter_field_day", field_sel, 1);
        check("enter_editing", editing, 1);
        repeat (3) press(0, 1, 0);
        press(1, 0, 0);
        check("field_month", field_sel, 2);
        press(1, 0, 0);
        check("field_year", field_sel, 3);
        press(1, 0, 0);
        repeat (3) @(negedge clk);
        check("basic_committed", exp_q.size(), 0);
        check("basic_editing_off", editing, 0);
        check("basic_field_none", field_sel, 0);

        // inc/dec in IDLE ignored
        press(0, 1, 0);
        press(0, 0, 1);
        check("idle_inc_ignored", editing, 0);

        // Wraps
        session("day_wrap_up",    mk(31, 1, 2023),  "mimmm",  mk(1, 1, 2023));
        session("day_wrap_leap",  mk(1, 2, 2024),   "mdmmm",  mk(29, 2, 2024));
        session("day_wrap_comm",  mk(1, 2, 2023),   "mdmmm",  mk(28, 2, 2023));
        session("mon_wrap_down",  mk(10, 1, 2023),  "mmdmm",  mk(10, 12, 2023));
        session("mon_wrap_up",    mk(10, 12, 2023), "mmimm",  mk(10, 1, 2023));
        session("year_wrap_up",   mk(10, 5, 4095),  "mmmim",  mk(10, 5, 0));
        session("year_wrap_down", mk(10, 5, 0),     "mmmdm",  mk(10, 5, 4095));
        session("out_of_range",   mk(0, 13, 2023),  "mmmm",   mk(1, 1, 2023));

        // Clamp on commit
        session("clamp_feb_comm", mk(31, 1, 2023),  "mmimm",  mk(28, 2, 2023));
        session("clamp_feb_leap", mk(31, 1, 2024),  "mmimm",  mk(29, 2, 2024));
        session("clamp_apr",      mk(31, 3, 2023),  "mmimm",  mk(30, 4, 2023));

        // Event qualification
        session("held_inc",       mk(10, 3, 2023),  "mhmmm",  mk(11, 3, 2023));
        session("inc_dec_same",   mk(10, 3, 2023),  "mbmmm",  mk(10, 3, 2023));
        date_cur = mk(10, 3, 2023);
        exp_q.push_back(mk(10, 3, 2023));
        press(1, 0, 0);
        press(1, 1, 0);
        check("mode_inc_field", field_sel, 2);
        press(1, 0, 0);
        press(1, 0, 0);
        repeat (3) @(negedge clk);
        check("mode_inc_committed", exp_q.size(), 0);

        // Reset in EDIT_MONTH aborts without a write
        date_cur = mk(5, 5, 2020);
        press(1, 0, 0);
        press(1, 0, 0);
        check("abort_in_month", field_sel, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_editing", editing, 0);
        check("abort_field", field_sel, 0);
        check("abort_date_ow", date_ow, 0);
        check("abort_date_set", date_set, RST_SET);
        repeat (4) @(negedge clk);

        // Timeout on the short-timeout instance
        @(negedge clk);
        to_mode = 1'b1;
        @(negedge clk);
        to_mode = 1'b0;
        n = 0;
        while (to_editing !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("to_entered", to_editing, 1);
        n = 0;
        while (to_editing === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_edit_cycles", n, 16);
        check("to_field_none", to_field, 0);
        check("to_date_set", to_set, RST_SET);
        repeat (4) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
